sha256_iter_core: RTL

Iterative, parametrised SHA-256/SHA-224 compression engine: one 512-bit block per transaction, R rounds per clock, with a valid/ready handshake on both sides. It keeps its own chaining value, so multi-block messages are hashed by streaming consecutive padded blocks. It is the sequential, area-scaled successor of the fully unrolled combinational `sha256` datapath and sits between a block packer/padder and the digest consumer.

---
 rtl/sha256_iter_core.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256/SHA-224 compression core: one 512-bit block per transaction,
// ROUNDS_PER_CYCLE rounds per clock, with an internal chaining value for multi-block messages.
module sha256_iter_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_mode224,
  input  logic [0:511] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:255] out
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_mode224;
  logic [6:0]  r_t;
  logic [31:0] r_work  [8];
  logic [31:0] r_base  [8];
  logic [31:0] r_chain [8];
  logic [31:0] r_win   [16];

  logic [31:0] w_work [8];
  logic [31:0] w_win  [16];
  logic [31:0] w_sel  [8];
  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic [31:0] w_new;
  logic [6:0]  w_t_next;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_sel[i] = in_first ? (in_mode224 ? IV224[i] : IV256[i]) : r_chain[i];
    end
  end

  // R chained rounds; the window slides one word per round so w_win[0] is always W[t].
  always_comb begin
    w_work = r_work;
    w_win  = r_win;
    w_t1   = '0;
    w_t2   = '0;
    w_new  = '0;
    for (int unsigned i = 0; i < R; i++) begin
      w_t1 = w_work[7] + bsig1(w_work[4]) + ((w_work[4] & w_work[5]) ^ (~w_work[4] & w_work[6]))
           + K[r_t[5:0] + 6'(i)] + w_win[0];
      w_t2 = bsig0(w_work[0])
           + ((w_work[0] & w_work[1]) ^ (w_work[0] & w_work[2]) ^ (w_work[1] & w_work[2]));
      w_new = ssig1(w_win[14]) + w_win[9] + ssig0(w_win[1]) + w_win[0];
      for (int j = 0; j < 15; j++) begin
        w_win[j] = w_win[j+1];
      end
      w_win[15] = w_new;
      w_work[7] = w_work[6];
      w_work[6] = w_work[5];
      w_work[5] = w_work[4];
      w_work[4] = w_work[3] + w_t1;
      w_work[3] = w_work[2];
      w_work[2] = w_work[1];
      w_work[1] = w_work[0];
      w_work[0] = w_t1 + w_t2;
    end
  end

  assign w_t_next = r_t + 7'(R);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mode224   <= 1'b0;
      r_t         <= '0;
      for (int i = 0; i < 8; i++) r_chain[i] <= IV256[i];
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_base <= w_sel;
            r_work <= w_sel;
            for (int j = 0; j < 16; j++) r_win[j] <= in_block[32*j +: 32];
            if (in_first) r_mode224 <= in_mode224;
            r_t        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StRound;
          end
        end
        StRound: begin
          r_work <= w_work;
          r_win  <= w_win;
          r_t    <= w_t_next;
          if (w_t_next == 7'd64) r_state <= StFinal;
        end
        StFinal: begin
          for (int i = 0; i < 8; i++) r_chain[i] <= r_base[i] + r_work[i];
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  always_comb begin
    out = '0;
    for (int i = 0; i < 8; i++) out[32*i +: 32] = r_chain[i];
    if (r_mode224) out[224 +: 32] = '0;
  end

endmodule
